// File: rtl/run_sequencer_if.sv
// Host-side handshake between the launch controller and whoever drives it:
// run request/abort and core done in, core start plus run results out.
interface run_sequencer_if #(
    parameter int CYCLE_W = 16
);
    logic               run_req;
    logic               abort;
    logic               core_done;
    logic               core_start;
    logic               busy;
    logic               result_valid;
    logic               timed_out;
    logic               aborted;
    logic [CYCLE_W-1:0] cycle_count;
    logic [7:0]         run_count;

    modport master (
        output run_req, abort, core_done,
        input  core_start, busy, result_valid, timed_out, aborted,
        input  cycle_count, run_count
    );

    modport slave (
        input  run_req, abort, core_done,
        output core_start, busy, result_valid, timed_out, aborted,
        output cycle_count, run_count
    );
endinterface

// File: rtl/run_sequencer.sv
// Launch controller for the CPU top level: owns every start edge, measures
// run length in cycles, enforces a timeout and reports one result per run.
module run_sequencer #(
    parameter int                 CYCLE_W        = 16,
    parameter logic [CYCLE_W-1:0] TIMEOUT_CYCLES = CYCLE_W'(16'hFFFF)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    run_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_RUN    = 2'd2,
        S_REPORT = 2'd3
    } state_e;

    // Counter value seen in the last RUN cycle before the timeout fires.
    localparam logic [CYCLE_W-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - CYCLE_W'(1);

    state_e             state_q;
    logic               core_start_q;
    logic               busy_q;
    logic               result_valid_q;
    logic               timed_out_q;
    logic               aborted_q;
    logic [CYCLE_W-1:0] cycle_cnt_q;
    logic [CYCLE_W-1:0] cycle_cnt_d;
    logic [7:0]         run_count_q;

    // Saturating increment of the RUN cycle counter.
    always_comb begin
        if (cycle_cnt_q == {CYCLE_W{1'b1}}) begin
            cycle_cnt_d = cycle_cnt_q;
        end else begin
            cycle_cnt_d = cycle_cnt_q + CYCLE_W'(1);
        end
    end

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            core_start_q   <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            timed_out_q    <= 1'b0;
            aborted_q      <= 1'b0;
            cycle_cnt_q    <= {CYCLE_W{1'b0}};
            run_count_q    <= 8'd0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Results are cleared on entry so they already read zero in ARM.
                    if (bus.run_req) begin
                        state_q      <= S_ARM;
                        core_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                        cycle_cnt_q  <= {CYCLE_W{1'b0}};
                        timed_out_q  <= 1'b0;
                        aborted_q    <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ARM: begin
                    // core_done still reflects the pc from before reset release.
                    if (bus.abort) begin
                        state_q        <= S_REPORT;
                        core_start_q   <= 1'b0;
                        result_valid_q <= 1'b1;
                        aborted_q      <= 1'b1;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    cycle_cnt_q <= cycle_cnt_d;
                    if (bus.abort) begin
                        state_q        <= S_REPORT;
                        core_start_q   <= 1'b0;
                        result_valid_q <= 1'b1;
                        aborted_q      <= 1'b1;
                    end else if (bus.core_done) begin
                        state_q        <= S_REPORT;
                        core_start_q   <= 1'b0;
                        result_valid_q <= 1'b1;
                        run_count_q    <= run_count_q + 8'd1;
                    end else if (cycle_cnt_q == TIMEOUT_LAST) begin
                        state_q        <= S_REPORT;
                        core_start_q   <= 1'b0;
                        result_valid_q <= 1'b1;
                        timed_out_q    <= 1'b1;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_REPORT: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q      <= S_IDLE;
                    core_start_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_start   = core_start_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = result_valid_q;
    assign bus.timed_out    = timed_out_q;
    assign bus.aborted      = aborted_q;
    assign bus.cycle_count  = cycle_cnt_q;
    assign bus.run_count    = run_count_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: table of run scenarios, randomized
// runs against an outcome model, back-to-back wrap and mid-run reset.
module tb_run_sequencer;

    localparam int T = 12;

    typedef struct {
        int ab;   // abort cycle: 0 = ARM, k = RUN cycle k, -1 = never
        int dn;   // first RUN cycle with core_done high, -1 = never
        int cyc;
        bit to;
        bit abd;
        bit dne;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   rc_exp = 0;
    vec_t tbl[10];

    run_sequencer_if #(.CYCLE_W(16)) bus ();

    run_sequencer #(.CYCLE_W(16), .TIMEOUT_CYCLES(16'd12)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Outcome of one run from the priority rules: earliest event wins, abort > done > timeout.
    task automatic model(input int ab, input int dn, output int cyc, output bit to,
                         output bit abd, output bit dne);
        int e_ab, e_dn;
        if (ab == 0) begin
            cyc = 0; to = 1'b0; abd = 1'b1; dne = 1'b0;
        end else begin
            e_ab = (ab > 0) ? ab : 1000;
            e_dn = (dn > 0) ? dn : 1000;
            cyc  = e_ab;
            if (e_dn < cyc) cyc = e_dn;
            if (T < cyc) cyc = T;
            abd = (e_ab == cyc);
            dne = !abd && (e_dn == cyc);
            to  = !abd && !dne;
        end
    endtask

    task automatic run_one(input int ab, input int dn, input int cyc, input bit to,
                           input bit abd, input bit dne);
        int  runs = 0;
        int  hi = 1;
        bit  got = 1'b0;
        @(negedge clk);
        bus.run_req   = 1'b1;
        bus.abort     = 1'b0;
        bus.core_done = 1'b0;
        @(negedge clk);
        bus.run_req = 1'b0;
        chk("arm_core_start", bus.core_start, 1);
        chk("arm_busy", bus.busy, 1);
        chk("arm_cleared", {bus.cycle_count, bus.timed_out, bus.aborted, bus.result_valid}, 0);
        bus.abort     = (ab == 0);
        bus.core_done = 1'($urandom_range(0, 1));
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (bus.result_valid) begin
                got = 1'b1;
                break;
            end
            runs++;
            if (bus.core_start) hi++;
            bus.abort     = (ab == k);
            bus.core_done = (dn > 0) && (k >= dn);
        end
        bus.abort     = 1'b0;
        bus.core_done = 1'b0;
        if (!got) chk("report_reached", 0, 1);
        if (dne) rc_exp = (rc_exp + 1) & 8'hFF;
        chk("rep_core_start", bus.core_start, 0);
        chk("rep_busy", bus.busy, 1);
        chk("rep_cycle_count", bus.cycle_count, cyc);
        chk("rep_timed_out", bus.timed_out, to);
        chk("rep_aborted", bus.aborted, abd);
        chk("rep_run_count", bus.run_count, rc_exp);
        chk("run_cycles_seen", runs, cyc);
        chk("start_high_cycles", hi, cyc + 1);
        @(negedge clk);
        chk("idle_pulse_done", {bus.result_valid, bus.busy, bus.core_start}, 0);
        chk("idle_hold_count", bus.cycle_count, cyc);
    endtask

    initial begin
        int cyc;
        bit to, abd, dne;
        int ab, dn;
        int pulses, hi, lo, gap_err, bad, seen;

        tbl[0] = '{-1, 10, 10, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{-1, -1, T,  1'b1, 1'b0, 1'b0};
        tbl[2] = '{-1, T,  T,  1'b0, 1'b0, 1'b1};
        tbl[3] = '{-1, 1,  1,  1'b0, 1'b0, 1'b1};
        tbl[4] = '{3,  -1, 3,  1'b0, 1'b1, 1'b0};
        tbl[5] = '{0,  -1, 0,  1'b0, 1'b1, 1'b0};
        tbl[6] = '{5,  5,  5,  1'b0, 1'b1, 1'b0};
        tbl[7] = '{T,  -1, T,  1'b0, 1'b1, 1'b0};
        tbl[8] = '{-1, 11, 11, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{0,  1,  0,  1'b0, 1'b1, 1'b0};

        bus.run_req   = 1'b0;
        bus.abort     = 1'b0;
        bus.core_done = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_flags", {bus.core_start, bus.busy, bus.result_valid, bus.timed_out, bus.aborted}, 0);
        chk("rst_cycle_count", bus.cycle_count, 0);
        chk("rst_run_count", bus.run_count, 0);
        rst           = 1'b0;
        bus.core_done = 1'b1;
        @(negedge clk);
        chk("idle_ignores_done", {bus.busy, bus.core_start, bus.run_count}, 0);

        for (int i = 0; i < 10; i++)
            run_one(tbl[i].ab, tbl[i].dn, tbl[i].cyc, tbl[i].to, tbl[i].abd, tbl[i].dne);

        for (int i = 0; i < 40; i++) begin
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, T + 2)) : -1;
            dn = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, T + 2));
            model(ab, dn, cyc, to, abd, dne);
            run_one(ab, dn, cyc, to, abd, dne);
        end

        // Back-to-back runs with run_req held, done in RUN cycle 2, 256 runs.
        pulses = 0; hi = 0; lo = 0; gap_err = 0; bad = 0; seen = 0;
        @(negedge clk);
        bus.run_req = 1'b1;
        for (int c = 0; c < 2000 && pulses < 256; c++) begin
            @(negedge clk);
            if (bus.core_start) begin
                if (hi == 0 && seen != 0 && lo < 2) gap_err++;
                hi++; lo = 0; seen = 1;
            end else begin
                hi = 0; lo++;
            end
            if (bus.result_valid) begin
                pulses++;
                if (bus.cycle_count != 16'd2 || bus.timed_out) bad++;
            end
            bus.core_done = (hi == 3);
            if (pulses == 256) bus.run_req = 1'b0;
        end
        bus.run_req   = 1'b0;
        bus.core_done = 1'b0;
        chk("b2b_pulses", pulses, 256);
        chk("b2b_start_gap", gap_err, 0);
        chk("b2b_results", bad, 0);
        chk("b2b_run_count_wrap", bus.run_count, rc_exp);
        @(negedge clk);
        chk("b2b_idle", {bus.busy, bus.core_start}, 0);

        // Reset in the middle of a run: no result for the interrupted run.
        bus.run_req = 1'b1;
        @(negedge clk);
        bus.run_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_run_start", bus.core_start, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_flags", {bus.core_start, bus.busy, bus.result_valid}, 0);
        chk("mid_rst_counts", {bus.cycle_count, bus.run_count}, 0);
        rst    = 1'b0;
        rc_exp = 0;
        bad    = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.result_valid || bus.busy) bad++;
        end
        chk("mid_rst_no_result", bad, 0);
        run_one(-1, 2, 2, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
